// File: rtl/pipe_pkg.sv
// Shared widths, ALU opcodes and EX/MEM record for the MIPS-subset pipeline.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PCW_W  = 30;

  typedef enum logic [2:0] {
    ALU_ADDU = 3'b000,
    ALU_SUBU = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_LUI  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] bus_b;
    logic [REG_AW-1:0] rw;
    logic              reg_wr;
    logic              mem_wr;
    logic              mem_to_reg;
  } exmem_t;

  // A later stage supplies a source only if it writes a non-zero matching register.
  function automatic logic fwd_hit(input logic wr_en, input logic [REG_AW-1:0] wr_reg,
                                   input logic [REG_AW-1:0] src_reg);
    return wr_en && (wr_reg != '0) && (wr_reg == src_reg);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding sources, redirect and EX/MEM outputs of the EX stage.
interface ex_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [PCW_W-1:0]  ex_PC_plus_4;
  logic [WORD_W-1:0] ex_busA;
  logic [WORD_W-1:0] ex_busB;
  logic [REG_AW-1:0] ex_Ra;
  logic [REG_AW-1:0] ex_Rb;
  logic [REG_AW-1:0] ex_Rw;
  logic [WORD_W-1:0] ex_imm16Ext;
  logic [25:0]       ex_target26;
  logic              ex_RegWr;
  logic              ex_RegDst;
  logic              ex_ALUsrc;
  logic              ex_Branch;
  logic              ex_Jump;
  logic              ex_MemWr;
  logic              ex_MemtoReg;
  logic [2:0]        ex_ALUctr;
  logic              mem_fwd_RegWr;
  logic [REG_AW-1:0] mem_fwd_Rw;
  logic [WORD_W-1:0] mem_fwd_data;
  logic              wb_RegWr;
  logic [REG_AW-1:0] wb_Rw;
  logic [WORD_W-1:0] wb_busW;
  logic              stall;
  logic              redirect;
  logic [PCW_W-1:0]  redirect_pc;
  logic              flush;
  logic [WORD_W-1:0] mem_ALUout;
  logic [WORD_W-1:0] mem_busB;
  logic [REG_AW-1:0] mem_Rw;
  logic              mem_RegWr;
  logic              mem_MemWr;
  logic              mem_MemtoReg;
  logic [CNT_W-1:0]  redirect_cnt;

  // Pipeline-control side driving the EX stage.
  modport master (
    output ex_PC_plus_4, ex_busA, ex_busB, ex_Ra, ex_Rb, ex_Rw, ex_imm16Ext, ex_target26,
           ex_RegWr, ex_RegDst, ex_ALUsrc, ex_Branch, ex_Jump, ex_MemWr, ex_MemtoReg,
           ex_ALUctr, mem_fwd_RegWr, mem_fwd_Rw, mem_fwd_data, wb_RegWr, wb_Rw, wb_busW,
           stall,
    input  redirect, redirect_pc, flush, mem_ALUout, mem_busB, mem_Rw, mem_RegWr,
           mem_MemWr, mem_MemtoReg, redirect_cnt
  );

  // The EX stage itself.
  modport slave (
    input  ex_PC_plus_4, ex_busA, ex_busB, ex_Ra, ex_Rb, ex_Rw, ex_imm16Ext, ex_target26,
           ex_RegWr, ex_RegDst, ex_ALUsrc, ex_Branch, ex_Jump, ex_MemWr, ex_MemtoReg,
           ex_ALUctr, mem_fwd_RegWr, mem_fwd_Rw, mem_fwd_data, wb_RegWr, wb_Rw, wb_busW,
           stall,
    output redirect, redirect_pc, flush, mem_ALUout, mem_busB, mem_Rw, mem_RegWr,
           mem_MemWr, mem_MemtoReg, redirect_cnt
  );
endinterface

// File: rtl/alu.sv
// 32-bit combinational ALU; overflow is ignored.
module alu
  import pipe_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [2:0]        ctr_i,
  output logic [WORD_W-1:0] result_o,
  output logic              zero_o
);

  // Decode the operation and compute the result.
  always_comb begin
    result_o = '0;
    unique case (alu_op_e'(ctr_i))
      ALU_ADDU: result_o = a_i + b_i;
      ALU_SUBU: result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(WORD_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(WORD_W-1){1'b0}}, (a_i < b_i)};
      ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect, EX/MEM register, redirect counter.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic       Clk,
  input logic       Rst_n,
  ex_stage_if.slave bus_io
);

  logic [WORD_W-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic              alu_zero;
  logic [REG_AW-1:0] dst;
  logic              taken;
  logic [PCW_W-1:0]  target;
  exmem_t            exmem_d, exmem_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              unused_imm_hi;

  // The branch offset is a word offset; its top two bits fall outside the PC field.
  assign unused_imm_hi = ^bus_io.ex_imm16Ext[31:30];

  // Forwarding muxes: MEM has priority over WB, register 0 is never forwarded.
  always_comb begin
    fwd_a = bus_io.ex_busA;
    fwd_b = bus_io.ex_busB;
    if (fwd_hit(bus_io.mem_fwd_RegWr, bus_io.mem_fwd_Rw, bus_io.ex_Ra)) begin
      fwd_a = bus_io.mem_fwd_data;
    end else if (fwd_hit(bus_io.wb_RegWr, bus_io.wb_Rw, bus_io.ex_Ra)) begin
      fwd_a = bus_io.wb_busW;
    end
    if (fwd_hit(bus_io.mem_fwd_RegWr, bus_io.mem_fwd_Rw, bus_io.ex_Rb)) begin
      fwd_b = bus_io.mem_fwd_data;
    end else if (fwd_hit(bus_io.wb_RegWr, bus_io.wb_Rw, bus_io.ex_Rb)) begin
      fwd_b = bus_io.wb_busW;
    end
  end

  assign op_b = bus_io.ex_ALUsrc ? bus_io.ex_imm16Ext : fwd_b;
  assign dst  = bus_io.ex_RegDst ? bus_io.ex_Rw : bus_io.ex_Rb;

  alu u_alu (
    .a_i      (fwd_a),
    .b_i      (op_b),
    .ctr_i    (bus_io.ex_ALUctr),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Redirect resolution; suppressed under reset and stall so it fires once when stall drops.
  always_comb begin
    taken  = Rst_n & ~bus_io.stall & (bus_io.ex_Jump | (bus_io.ex_Branch & alu_zero));
    target = bus_io.ex_PC_plus_4 + bus_io.ex_imm16Ext[PCW_W-1:0];
    if (bus_io.ex_Jump) begin
      target = {bus_io.ex_PC_plus_4[PCW_W-1:PCW_W-4], bus_io.ex_target26};
    end
  end

  assign bus_io.redirect    = taken;
  assign bus_io.flush       = taken;
  assign bus_io.redirect_pc = taken ? target : '0;

  // Next EX/MEM contents and saturating counter value.
  always_comb begin
    exmem_d = exmem_q;
    if (!bus_io.stall) begin
      exmem_d.alu_out    = alu_res;
      exmem_d.bus_b      = fwd_b;
      exmem_d.rw         = dst;
      exmem_d.reg_wr     = bus_io.ex_RegWr;
      exmem_d.mem_wr     = bus_io.ex_MemWr;
      exmem_d.mem_to_reg = bus_io.ex_MemtoReg;
    end
    cnt_d = cnt_q;
    if (taken && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // EX/MEM register and counter with synchronous reset (reset beats stall).
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      exmem_q <= '0;
      cnt_q   <= '0;
    end else begin
      exmem_q <= exmem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.mem_ALUout   = exmem_q.alu_out;
  assign bus_io.mem_busB     = exmem_q.bus_b;
  assign bus_io.mem_Rw       = exmem_q.rw;
  assign bus_io.mem_RegWr    = exmem_q.reg_wr;
  assign bus_io.mem_MemWr    = exmem_q.mem_wr;
  assign bus_io.mem_MemtoReg = exmem_q.mem_to_reg;
  assign bus_io.redirect_cnt = cnt_q;

endmodule
